// File: rtl/centrifugado_pkg.sv
// Shared types and default constants for the spin-cycle controller.
// No logic here; imported by the controller.
package centrifugado_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int STEP_S_DEF   = 30;
   localparam int TICK_DIV_DEF = 50_000_000;

endpackage

// File: rtl/boton_debounce.sv
// Front-panel button: 2-flop sync, stable-time debounce, rising-edge pulse.
// Latency 2 + DEB_CYCLES cycles from raw edge to pulse; no backpressure.
module boton_debounce #(
   parameter int DEB_CYCLES = 500_000
) (
   input  logic clk_in,
   input  logic iEncender,
   input  logic iBoton,
   output logic oPulso
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          deb_q,   deb_d;
   logic          pulse_q, pulse_d;
   logic [CW-1:0] cnt_q,   cnt_d;

   // Counter only runs while the synchronised level disagrees with the accepted one,
   // so any bounce back to the old level restarts the stable-time window.
   always_comb begin
      sync1_d = iBoton;
      sync2_d = sync1_q;
      deb_d   = deb_q;
      cnt_d   = '0;
      pulse_d = 1'b0;
      if (sync2_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d   = sync2_q;
            pulse_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_in or negedge iEncender) begin
      if (!iEncender) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         deb_q   <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q   <= deb_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
      end
   end

   assign oPulso = pulse_q;

endmodule

// File: rtl/centrifugado_ctrl.sv
// Spin-cycle controller: level select, countdown with pause, abort on mode drop.
// Start takes effect next cycle; 1 s ticks every TICK_DIV cycles; no backpressure.
module centrifugado_ctrl
   import centrifugado_pkg::*;
#(
   parameter int NUM_LEVELS = 4,
   parameter int STEP_S     = STEP_S_DEF,
   parameter int TICK_DIV   = TICK_DIV_DEF,
   parameter int DEB_CYCLES = 500_000,
   localparam int LW        = $clog2(NUM_LEVELS),
   localparam int SW        = $clog2(NUM_LEVELS * STEP_S + 1)
) (
   input  logic                  clk_in,
   input  logic                  iEncender,
   input  logic                  iBoton_TiempoCentri,
   input  logic                  iCentrifugarL,
   input  logic                  iStart,
   input  logic                  iPausa,
   output logic [NUM_LEVELS-1:0] oLed_Centri,
   output logic [LW-1:0]         oNivel,
   output logic [SW-1:0]         oSegundos,
   output logic                  oMotor,
   output logic                  oFin
);

   localparam int PW = $clog2(TICK_DIV + 1);
   localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
   localparam logic [LW-1:0] LEVEL_LAST = LW'(NUM_LEVELS - 1);
   localparam logic [SW-1:0] STEP_W     = SW'(STEP_S);

   state_e        state_q, state_d;
   logic [LW-1:0] level_q, level_d;
   logic          sel_q,   sel_d;
   logic [SW-1:0] seg_q,   seg_d;
   logic [PW-1:0] pre_q,   pre_d;

   logic          press;
   logic          do_count;
   logic [SW-1:0] lvl_ext;
   logic [SW-1:0] seg_load;

   boton_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_boton (
      .clk_in    (clk_in),
      .iEncender (iEncender),
      .iBoton    (iBoton_TiempoCentri),
      .oPulso    (press)
   );

   assign lvl_ext  = {{(SW-LW){1'b0}}, level_q};
   assign seg_load = (lvl_ext + SW'(1)) * STEP_W;

   always_comb begin
      state_d  = state_q;
      level_d  = level_q;
      sel_d    = sel_q;
      seg_d    = seg_q;
      pre_d    = pre_q;
      do_count = 1'b0;

      case (state_q)
         IDLE: begin
            if (iStart && sel_q) begin
               seg_d   = seg_load;
               pre_d   = '0;
               state_d = RUN;
            end else if (press) begin
               // The first press only lights the current level; later presses advance it.
               if (!sel_q)                 sel_d   = 1'b1;
               else if (level_q == LEVEL_LAST) level_d = '0;
               else                        level_d = level_q + LW'(1);
            end
         end
         RUN: begin
            if (iPausa) state_d = PAUSE;
            else        do_count = 1'b1;
         end
         PAUSE: begin
            // Resuming counts on the release edge so pause time adds exactly its length.
            if (!iPausa) begin
               state_d  = RUN;
               do_count = 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            seg_d   = '0;
         end
         default: state_d = IDLE;
      endcase

      if (do_count) begin
         if (pre_q == TICK_LAST) begin
            pre_d = '0;
            seg_d = seg_q - SW'(1);
            if (seg_q == SW'(1)) state_d = DONE;
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end

      if (!iCentrifugarL) begin
         state_d = IDLE;
         level_d = '0;
         sel_d   = 1'b0;
         seg_d   = '0;
         pre_d   = '0;
      end
   end

   always_ff @(posedge clk_in or negedge iEncender) begin
      if (!iEncender) begin
         state_q <= IDLE;
         level_q <= '0;
         sel_q   <= 1'b0;
         seg_q   <= '0;
         pre_q   <= '0;
      end else begin
         state_q <= state_d;
         level_q <= level_d;
         sel_q   <= sel_d;
         seg_q   <= seg_d;
         pre_q   <= pre_d;
      end
   end

   assign oLed_Centri = sel_q ? (NUM_LEVELS'(1) << level_q) : '0;
   assign oNivel      = level_q;
   assign oSegundos   = seg_q;
   assign oMotor      = (state_q == RUN);
   assign oFin        = (state_q == DONE);

endmodule

// File: tb/tb_centrifugado_ctrl.sv
// Directed bench for centrifugado_ctrl with small parameters.
module tb_centrifugado_ctrl;

   localparam int NL = 4;
   localparam int SW = $clog2(NL * 3 + 1);

   logic          clk_in = 1'b0;
   logic          iEncender = 1'b0;
   logic          iBoton_TiempoCentri = 1'b0;
   logic          iCentrifugarL = 1'b1;
   logic          iStart = 1'b0;
   logic          iPausa = 1'b0;
   logic [NL-1:0] oLed_Centri;
   logic [1:0]    oNivel;
   logic [SW-1:0] oSegundos;
   logic          oMotor;
   logic          oFin;

   int vectors = 0;
   int miscompares = 0;

   centrifugado_ctrl #(
      .NUM_LEVELS(NL), .STEP_S(3), .TICK_DIV(10), .DEB_CYCLES(4)
   ) dut (
      .clk_in              (clk_in),
      .iEncender           (iEncender),
      .iBoton_TiempoCentri (iBoton_TiempoCentri),
      .iCentrifugarL       (iCentrifugarL),
      .iStart              (iStart),
      .iPausa              (iPausa),
      .oLed_Centri         (oLed_Centri),
      .oNivel              (oNivel),
      .oSegundos           (oSegundos),
      .oMotor              (oMotor),
      .oFin                (oFin)
   );

   always #5 clk_in = ~clk_in;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic press(input int len);
      iBoton_TiempoCentri = 1'b1;
      step(len);
      iBoton_TiempoCentri = 1'b0;
      step(14);
   endtask

   task automatic start_pulse();
      iStart = 1'b1;
      step(1);
      iStart = 1'b0;
   endtask

   task automatic test_reset();
      iEncender = 1'b0;
      step(3);
      iEncender = 1'b1;
      step(2);
      vectors++;
      if ({oLed_Centri, oNivel, oSegundos, oMotor, oFin} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got led=%b niv=%0d seg=%0d mot=%b fin=%b want all 0",
                  oLed_Centri, oNivel, oSegundos, oMotor, oFin);
      end
   endtask

   task automatic test_levels();
      logic [NL-1:0] exp_led [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      logic [1:0]    exp_niv [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      for (int k = 0; k < 5; k++) begin
         press(10);
         vectors++;
         if (oLed_Centri !== exp_led[k] || oNivel !== exp_niv[k]) begin
            miscompares++;
            $display("FAIL level_press%0d got led=%b niv=%0d want led=%b niv=%0d",
                     k, oLed_Centri, oNivel, exp_led[k], exp_niv[k]);
         end
      end
   endtask

   task automatic test_glitch_hold();
      press(2);
      vectors++;
      if (oLed_Centri !== 4'b0001) begin
         miscompares++;
         $display("FAIL glitch got led=%b want 0001", oLed_Centri);
      end
      press(100);
      vectors++;
      if (oLed_Centri !== 4'b0010) begin
         miscompares++;
         $display("FAIL held_press got led=%b want 0010", oLed_Centri);
      end
   endtask

   task automatic test_run();
      int cyc;
      int fins;
      start_pulse();
      vectors++;
      if (oSegundos !== SW'(6) || oMotor !== 1'b1) begin
         miscompares++;
         $display("FAIL run_load got seg=%0d mot=%b want seg=6 mot=1", oSegundos, oMotor);
      end
      cyc = 0;
      fins = 0;
      while (cyc < 200) begin
         step(1);
         cyc++;
         if (cyc == 10) begin
            vectors++;
            if (oSegundos !== SW'(5)) begin
               miscompares++;
               $display("FAIL run_first_tick got seg=%0d want 5", oSegundos);
            end
         end
         if (oFin) break;
      end
      vectors++;
      if (cyc != 60 || oSegundos !== '0) begin
         miscompares++;
         $display("FAIL run_done got cycles=%0d seg=%0d want cycles=60 seg=0", cyc, oSegundos);
      end
      for (int i = 0; i < 5; i++) begin
         step(1);
         if (oFin) fins++;
      end
      vectors++;
      if (fins != 0 || oLed_Centri !== 4'b0010 || oMotor !== 1'b0 || oSegundos !== '0) begin
         miscompares++;
         $display("FAIL run_idle got extra_fin=%0d led=%b mot=%b seg=%0d want 0 0010 0 0",
                  fins, oLed_Centri, oMotor, oSegundos);
      end
   endtask

   task automatic test_pause();
      int cyc;
      start_pulse();
      cyc = 0;
      while (cyc < 300) begin
         step(1);
         cyc++;
         if (cyc == 15) iPausa = 1'b1;
         if (cyc == 40) iPausa = 1'b0;
         if (cyc == 20 || cyc == 39) begin
            vectors++;
            if (oSegundos !== SW'(5) || oMotor !== 1'b0) begin
               miscompares++;
               $display("FAIL pause_frozen@%0d got seg=%0d mot=%b want seg=5 mot=0",
                        cyc, oSegundos, oMotor);
            end
         end
         if (oFin) break;
      end
      vectors++;
      if (cyc != 85) begin
         miscompares++;
         $display("FAIL pause_total got cycles=%0d want 85", cyc);
      end
      step(2);
   endtask

   task automatic test_abort();
      int fins;
      start_pulse();
      step(20);
      iCentrifugarL = 1'b0;
      step(1);
      vectors++;
      if (oMotor !== 1'b0 || oLed_Centri !== '0 || oSegundos !== '0 || oNivel !== '0 || oFin !== 1'b0) begin
         miscompares++;
         $display("FAIL abort got mot=%b led=%b seg=%0d niv=%0d fin=%b want all 0",
                  oMotor, oLed_Centri, oSegundos, oNivel, oFin);
      end
      fins = 0;
      for (int i = 0; i < 80; i++) begin
         step(1);
         if (oFin || oMotor) fins++;
      end
      iCentrifugarL = 1'b1;
      step(1);
      start_pulse();
      step(1);
      vectors++;
      if (fins != 0 || oMotor !== 1'b0 || oSegundos !== '0) begin
         miscompares++;
         $display("FAIL abort_nostart got activity=%0d mot=%b seg=%0d want 0 0 0",
                  fins, oMotor, oSegundos);
      end
   endtask

   task automatic test_async_reset();
      press(10);
      start_pulse();
      vectors++;
      if (oSegundos !== SW'(3) || oMotor !== 1'b1) begin
         miscompares++;
         $display("FAIL level0_load got seg=%0d mot=%b want seg=3 mot=1", oSegundos, oMotor);
      end
      step(7);
      #2;
      iEncender = 1'b0;
      #1;
      vectors++;
      if ({oLed_Centri, oNivel, oSegundos, oMotor, oFin} !== '0) begin
         miscompares++;
         $display("FAIL async_reset got led=%b niv=%0d seg=%0d mot=%b fin=%b want all 0",
                  oLed_Centri, oNivel, oSegundos, oMotor, oFin);
      end
      step(2);
      iEncender = 1'b1;
      step(10);
      vectors++;
      if (oLed_Centri !== '0 || oMotor !== 1'b0) begin
         miscompares++;
         $display("FAIL post_reset got led=%b mot=%b want 0 0", oLed_Centri, oMotor);
      end
   endtask

   initial begin
      test_reset();
      test_levels();
      test_glitch_hold();
      test_run();
      test_pause();
      test_abort();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/centrifugado_ctrl.md
CENTRIFUGADO_CTRL -- requirements
Module: centrifugado_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_LEVELS, default 4, number of selectable spin-time levels (2..16).
REQ-002 The block SHALL have parameter STEP_S, default 30, seconds of spin added per level.
REQ-003 The block SHALL have parameter TICK_DIV, default 50_000_000, clk_in cycles per 1 s tick.
REQ-004 The block SHALL have parameter DEB_CYCLES, default 500_000, button debounce stable-time in clk_in cycles.
REQ-005 The block SHALL have port clk_in, input, 1 bit, the single clock; all flops are clocked on its rising edge.
REQ-006 The block SHALL have port iEncender, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port iBoton_TiempoCentri, input, 1 bit, raw asynchronous level-select button.
REQ-008 The block SHALL have port iCentrifugarL, input, 1 bit, spin mode enable; low aborts and clears the selection.
REQ-009 The block SHALL have port iStart, input, 1 bit, one-cycle synchronous start request.
REQ-010 The block SHALL have port iPausa, input, 1 bit, synchronous level pause.
REQ-011 The block SHALL have port oLed_Centri, output, NUM_LEVELS bits, one-hot selected level (bit k = level k).
REQ-012 The block SHALL have port oNivel, output, clog2(NUM_LEVELS) bits, selected level index.
REQ-013 The block SHALL have port oSegundos, output, SW = clog2(NUM_LEVELS*STEP_S+1) bits, remaining spin seconds.
REQ-014 The block SHALL have port oMotor, output, 1 bit, motor drive, high only in RUN.
REQ-015 The block SHALL have port oFin, output, 1 bit, one-cycle pulse when the spin completes.

Function
REQ-016 The block SHALL pass iBoton_TiempoCentri through a 2-flop synchroniser, then a debouncer that accepts a new level only after DEB_CYCLES consecutive equal samples.
REQ-017 A debounced rising edge SHALL produce exactly one press event; holding the button SHALL produce no further events.
REQ-018 The FSM SHALL have the states IDLE, RUN, PAUSE and DONE.
REQ-019 In IDLE with iCentrifugarL=1, a press event SHALL advance the level by 1.
REQ-020 A press event at level NUM_LEVELS-1 SHALL wrap the level to 0.
REQ-021 Press events in RUN, PAUSE or DONE SHALL be ignored.
REQ-022 oLed_Centri SHALL be zero until the first press after clear; afterwards it SHALL be one-hot at oNivel.
REQ-023 A "selected" flag SHALL be set by the first press and cleared by a clear.
REQ-024 In IDLE, iStart=1 with iCentrifugarL=1 and selected=1 SHALL load oSegundos = (oNivel+1)*STEP_S, clear the tick prescaler and enter RUN on the next cycle.
REQ-025 iStart with selected=0 SHALL be ignored.
REQ-026 In RUN, a prescaler counting 0..TICK_DIV-1 SHALL decrement oSegundos by 1 on each wrap.
REQ-027 The first decrement SHALL occur TICK_DIV cycles after entering RUN.
REQ-028 In RUN, the decrement taking oSegundos from 1 to 0 SHALL move the FSM to DONE.
REQ-029 oFin SHALL be high for exactly the cycle on which DONE is entered.
REQ-030 In RUN with iPausa=1, the FSM SHALL enter PAUSE, freezing both the prescaler and oSegundos.
REQ-031 In PAUSE with iPausa=0, the FSM SHALL return to RUN and resume counting from the frozen prescaler value.
REQ-032 If iPausa=1 and a tick occur in the same cycle, pause SHALL win and no decrement SHALL occur.
REQ-033 DONE SHALL return to IDLE on the next cycle, keeping the level and selected flag and setting oSegundos to 0.
REQ-034 iCentrifugarL=0 in any state SHALL, on the next edge, force IDLE, level 0, selected=0, oSegundos=0, oMotor=0 and no oFin; this SHALL take priority over every other event.
REQ-035 The level multiplication SHALL be performed at width SW with no truncation.

Reset
REQ-036 iEncender=0 SHALL asynchronously force state IDLE, level 0, selected=0, oLed_Centri=0, oNivel=0, oSegundos=0, oMotor=0, oFin=0, prescaler 0, debounce counter 0, and synchroniser/debounced button flops 0.
REQ-037 Reset deassertion SHALL occur with no pending press event.
REQ-038 Reset asserted mid-RUN SHALL drop oMotor immediately, asynchronously.

Structure
REQ-039 A shared package SHALL hold the FSM state enum (IDLE, RUN, PAUSE, DONE) and default constants STEP_S and TICK_DIV.
REQ-040 The synchroniser plus debouncer plus edge detector SHALL be a sub-module boton_debounce (clk_in, iEncender, raw input, pulse output), reusable for the other front-panel buttons.

Verification
REQ-041 With NUM_LEVELS=4, DEB_CYCLES=4, TICK_DIV=10, STEP_S=3: 5 clean presses -> oLed_Centri 0001, 0010, 0100, 1000, 0001 (wrap).
REQ-042 A 2-cycle glitch on the button -> no level change; a held press of 100 cycles -> exactly one increment.
REQ-043 Level 1, then iStart -> oSegundos=6, oMotor=1; after 60 cycles oSegundos=0 and oFin is pulsed once; back in IDLE oLed_Centri=0010.
REQ-044 iPausa high for 25 cycles mid-RUN -> oSegundos frozen and oMotor=0; total RUN-to-DONE time equals 60+25 cycles.
REQ-045 iCentrifugarL dropped mid-RUN -> next cycle IDLE, oLed_Centri=0, oSegundos=0, no oFin; iStart before any press -> ignored.
REQ-046 iEncender pulsed low mid-RUN -> all outputs 0 with no clock edge required.
